decoder_pipe: RTL

DECODER_PIPE -- requirements
Module: decoder_pipe

---
 rtl/decoder_pipe.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/decoder_pipe.sv
// decoder_pipe: decodes a code into a one-hot / thermometer / inverted one-hot
// word and queues {word, code} in a 2-entry FIFO. The block can also sweep
// every code 0..2**IN_W-1 internally, decoding each one with the mode that was
// present when the sweep started.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   input handshake for in_code / in_mode
//   in_code, in_mode      code to decode; mode 00 one-hot, 01 thermometer,
//                         10 inverted one-hot, 11 all zeros
//   scan_start            one-cycle request to sweep all codes (IDLE only)
//   out_valid / out_ready output handshake for out_data / out_code
//   out_data, out_code    oldest stored decoded word and its source code
//   busy                  high while a sweep is running or draining
//
// state | meaning
// IDLE  | accepting codes from the input port
// SCAN  | pushing the internal sweep counter, input port closed
// DRAIN | sweep fully queued, waiting for the FIFO to empty
module decoder_pipe #(
    parameter int IN_W = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_W-1:0]      in_code,
    input  logic [1:0]           in_mode,
    input  logic                 scan_start,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2**IN_W-1:0]   out_data,
    output logic [IN_W-1:0]      out_code,
    output logic                 busy
);

    localparam int OUT_W = 2**IN_W;
    // One extra bit so the counter moves past the last code instead of wrapping.
    localparam logic [IN_W:0] SCAN_LAST = (IN_W+1)'(OUT_W - 1);
    localparam logic [IN_W:0] SCAN_ONE  = (IN_W+1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         count_q, count_d;
    logic               wr_ptr_q, rd_ptr_q;
    logic [IN_W:0]      scan_q, scan_d;
    logic [1:0]         scan_mode_q, scan_mode_d;
    logic [OUT_W-1:0]   data_q [2];
    logic [IN_W-1:0]    code_q [2];

    logic               push, pop;
    logic [OUT_W-1:0]   push_data;
    logic [IN_W-1:0]    push_code;

    function automatic logic [OUT_W-1:0] decode(input logic [IN_W-1:0] code,
                                                input logic [1:0] mode);
        logic [OUT_W-1:0] w;
        w = '0;
        for (int i = 0; i < OUT_W; i++) begin
            case (mode)
                2'b00:   w[i] = (i == int'(code));
                2'b01:   w[i] = (i <= int'(code));
                2'b10:   w[i] = (i != int'(code));
                default: w[i] = 1'b0;
            endcase
        end
        return w;
    endfunction

    // rst is folded in so in_ready reads 0 while reset is held, even though
    // the registered state already looks like an empty IDLE block.
    assign in_ready  = !rst && (state_q == ST_IDLE) && (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = data_q[rd_ptr_q];
    assign out_code  = code_q[rd_ptr_q];
    assign busy      = (state_q != ST_IDLE);
    assign pop       = out_valid && out_ready;

    always_comb begin
        state_d     = state_q;
        scan_d      = scan_q;
        scan_mode_d = scan_mode_q;
        push        = 1'b0;
        push_data   = decode(in_code, in_mode);
        push_code   = in_code;
        case (state_q)
            ST_IDLE: begin
                push = in_valid && in_ready;
                if (scan_start) begin
                    state_d     = ST_SCAN;
                    scan_d      = '0;
                    scan_mode_d = in_mode;
                end
            end
            ST_SCAN: begin
                push_data = decode(scan_q[IN_W-1:0], scan_mode_q);
                push_code = scan_q[IN_W-1:0];
                // A pop on this edge frees a slot for the sweep push.
                if (count_q != 2'd2 || pop) begin
                    push   = 1'b1;
                    scan_d = scan_q + SCAN_ONE;
                    if (scan_q == SCAN_LAST) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (count_q == 2'd0 || (count_q == 2'd1 && pop)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            count_q     <= 2'd0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            scan_q      <= '0;
            scan_mode_q <= 2'b00;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_q ^ push;
            rd_ptr_q    <= rd_ptr_q ^ pop;
            scan_q      <= scan_d;
            scan_mode_q <= scan_mode_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                code_q[i] <= '0;
            end
        end else if (push) begin
            data_q[wr_ptr_q] <= push_data;
            code_q[wr_ptr_q] <= push_code;
        end
    end

endmodule
